// File: rtl/mouse_cursor_overlay.sv
// Overlays a solid square cursor on a grayscale valid/ready pixel stream; position commits only at start-of-frame.
// Optional CURSOR_BLINK_EN macro enables frame-counted cursor blinking.
module mouse_cursor_overlay #(
  parameter int               H_RES        = 640,
  parameter int               V_RES        = 480,
  parameter int               CUR_SIZE     = 8,
  parameter int               PIX_W        = 8,
  parameter logic [PIX_W-1:0] CUR_COLOR    = 8'hFF,
  parameter int               BLINK_FRAMES = 30
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [18:0]      mouse_pos,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [9:0]       s_x,
  input  logic [8:0]       s_y,
  input  logic             s_sof,
  input  logic [PIX_W-1:0] s_pixel,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sof,
  output logic [PIX_W-1:0] m_pixel,
  output logic [9:0]       cursor_x,
  output logic [8:0]       cursor_y
);

  logic [18:0]      pos_q;
  logic             pending;
  logic [9:0]       clamp_x;
  logic [8:0]       clamp_y;
  logic             differs;
  logic             adv1;
  logic             adv2;
  logic             accept;
  logic             commit;
  logic [9:0]       eff_x;
  logic [8:0]       eff_y;
  logic             raw_hit;
  logic             beat_vis;
  logic             v1;
  logic             sof1;
  logic             hit1;
  logic [PIX_W-1:0] pix1;

  // A sof beat that commits must already be drawn with the new position, so hit uses the post-commit values.
  always_comb begin
    clamp_x = (pos_q[9:0] > 10'(H_RES - 1)) ? 10'(H_RES - 1) : pos_q[9:0];
    clamp_y = (pos_q[18:10] > 9'(V_RES - 1)) ? 9'(V_RES - 1) : pos_q[18:10];
    differs = {clamp_y, clamp_x} != {cursor_y, cursor_x};
    adv2    = !m_valid || m_ready;
    adv1    = !v1 || adv2;
    accept  = s_valid && adv1;
    commit  = accept && s_sof && (pending || differs);
    eff_x   = commit ? clamp_x : cursor_x;
    eff_y   = commit ? clamp_y : cursor_y;
    raw_hit = ({1'b0, s_x} >= {1'b0, eff_x}) &&
              ({1'b0, s_x} <  ({1'b0, eff_x} + 11'(CUR_SIZE))) &&
              ({1'b0, s_y} >= {1'b0, eff_y}) &&
              ({1'b0, s_y} <  ({1'b0, eff_y} + 10'(CUR_SIZE)));
  end

  assign s_ready = adv1;

`ifdef CURSOR_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] frame_cnt;
  logic             visible;
  logic             frame_vis;

  // Visibility is decided at each sof from the pre-toggle state and held for that whole frame.
  assign beat_vis = (accept && s_sof) ? visible : frame_vis;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      visible   <= 1'b1;
      frame_vis <= 1'b1;
    end else if (accept && s_sof) begin
      frame_vis <= visible;
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        visible   <= !visible;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  assign beat_vis = 1'b1;
`endif

  // Position sampling, commit tracking and the two pipeline stages.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pos_q    <= '0;
      pending  <= 1'b0;
      cursor_x <= '0;
      cursor_y <= '0;
      v1       <= 1'b0;
      sof1     <= 1'b0;
      hit1     <= 1'b0;
      pix1     <= '0;
      m_valid  <= 1'b0;
      m_sof    <= 1'b0;
      m_pixel  <= '0;
    end else begin
      pos_q <= mouse_pos;
      if (commit) begin
        cursor_x <= clamp_x;
        cursor_y <= clamp_y;
        pending  <= 1'b0;
      end else begin
        pending <= differs;
      end
      if (adv1) begin
        v1 <= s_valid;
        if (s_valid) begin
          sof1 <= s_sof;
          hit1 <= raw_hit && beat_vis;
          pix1 <= s_pixel;
        end
      end
      if (adv2) begin
        m_valid <= v1;
        if (v1) begin
          m_sof   <= sof1;
          m_pixel <= hit1 ? CUR_COLOR : pix1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mouse_cursor_overlay.sv
// Randomized self-checking bench for mouse_cursor_overlay against a frame-level cursor/queue reference model.
module tb_mouse_cursor_overlay;

  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int CUR   = 8;

  typedef struct {
    logic       sof;
    logic [7:0] pix;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [18:0] mouse_pos = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [9:0]  s_x = '0;
  logic [8:0]  s_y = '0;
  logic        s_sof = 1'b0;
  logic [7:0]  s_pixel = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_sof;
  logic [7:0]  m_pixel;
  logic [9:0]  cursor_x;
  logic [8:0]  cursor_y;

  int    compared = 0;
  int    mismatched = 0;
  beat_t exp_q[$];
  int    mdl_cx = 0;
  int    mdl_cy = 0;
  int    mdl_px = 0;
  int    mdl_py = 0;
  bit    last_accept = 0;
  bit    rand_ready = 0;
  int    low_left = 0;

  mouse_cursor_overlay dut (
    .clk(clk), .reset_n(reset_n), .mouse_pos(mouse_pos),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
    .s_sof(s_sof), .s_pixel(s_pixel), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_pixel(m_pixel), .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v > hi) ? hi : v;
  endfunction

  function automatic bit inside_cursor(input int sx, input int sy);
    return (sx >= mdl_cx) && (sx < mdl_cx + CUR) && (sy >= mdl_cy) && (sy < mdl_cy + CUR);
  endfunction

  // One clock: check what the last edge produced, then predict what the next edge does.
  task automatic cycle();
    int    occ;
    bit    exp_ready;
    beat_t b;
    @(negedge clk);
    last_accept = 0;
    if (!reset_n) begin
      exp_q.delete();
      mdl_cx = 0; mdl_cy = 0; mdl_px = 0; mdl_py = 0;
    end else begin
      checkOutput("cursor_x", 32'(cursor_x), 32'(mdl_cx));
      checkOutput("cursor_y", 32'(cursor_y), 32'(mdl_cy));
      occ = exp_q.size();
      exp_ready = (occ < 2) || m_ready;
      checkOutput("s_ready", 32'(s_ready), 32'(exp_ready));
      if (occ == 0) begin
        checkOutput("m_valid_idle", 32'(m_valid), 32'd0);
      end else if (m_valid && m_ready) begin
        b = exp_q.pop_front();
        checkOutput("m_pixel", 32'(m_pixel), 32'(b.pix));
        checkOutput("m_sof", 32'(m_sof), 32'(b.sof));
      end
      if (s_valid && exp_ready) begin
        last_accept = 1;
        if (s_sof) begin
          mdl_cx = clampi(mdl_px, H_RES - 1);
          mdl_cy = clampi(mdl_py, V_RES - 1);
        end
        b.sof = s_sof;
        b.pix = inside_cursor(int'(s_x), int'(s_y)) ? 8'hFF : s_pixel;
        exp_q.push_back(b);
      end
      mdl_px = int'(mouse_pos[9:0]);
      mdl_py = int'(mouse_pos[18:10]);
    end
    @(posedge clk);
    #1;
    if (rand_ready) begin
      if (low_left > 0) begin
        m_ready = 1'b0;
        low_left--;
      end else begin
        m_ready = ($urandom_range(0, 3) != 0);
      end
    end
  endtask

  task automatic applyStimulus(input int x, input int y, input bit sof);
    int waited = 0;
    s_valid = 1'b1;
    s_x     = 10'(x);
    s_y     = 9'(y);
    s_sof   = sof;
    s_pixel = 8'($urandom_range(0, 254));
    do begin
      cycle();
      waited++;
    end while (!last_accept && waited < 40);
    if (!last_accept) checkOutput("accept_timeout", 32'(last_accept), 32'd1);
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic setMouse(input int x, input int y);
    mouse_pos = {9'(y), 10'(x)};
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int xs, ys, nx, ny;

    repeat (3) cycle();
    reset_n = 1'b1;
    idle(2);

    // First beat after reset: empty stage 2 after one edge, output after two.
    applyStimulus(300, 300, 1'b0);
    checkOutput("lat_stage1", 32'(m_valid), 32'd0);
    cycle();
    checkOutput("lat_out", 32'(m_valid), 32'd1);
    idle(3);

    // Commit happens only at the next sof.
    applyStimulus(0, 0, 1'b1);
    setMouse(100, 50);
    applyStimulus(100, 50, 1'b0);
    applyStimulus(3, 3, 1'b0);
    applyStimulus(0, 0, 1'b1);
    checkOutput("commit_x", 32'(cursor_x), 32'd100);
    checkOutput("commit_y", 32'(cursor_y), 32'd50);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(100 + 7 * (i % 2), 50 + 7 * (i / 2), 1'b0);
    end
    applyStimulus(108, 50, 1'b0);
    applyStimulus(100, 58, 1'b0);
    applyStimulus(99, 50, 1'b0);
    idle(4);

    // Clamp to the last visible pixel.
    setMouse(1000, 500);
    idle(2);
    applyStimulus(0, 0, 1'b1);
    checkOutput("clamp_x", 32'(cursor_x), 32'd639);
    checkOutput("clamp_y", 32'(cursor_y), 32'd479);
    applyStimulus(639, 479, 1'b0);
    applyStimulus(638, 479, 1'b0);
    applyStimulus(639, 478, 1'b0);
    idle(4);

    // Mouse moves on the very cycle the sof beat is accepted.
    setMouse(100, 50);
    applyStimulus(0, 0, 1'b1);
    idle(3);
    setMouse(200, 100);
    applyStimulus(0, 0, 1'b1);
    applyStimulus(200, 100, 1'b0);
    checkOutput("race_keep_x", 32'(cursor_x), 32'd100);
    applyStimulus(0, 0, 1'b1);
    checkOutput("race_new_x", 32'(cursor_x), 32'd200);
    applyStimulus(200, 100, 1'b0);
    applyStimulus(207, 107, 1'b0);
    idle(4);

    // Random frames under random backpressure, including a forced 5-cycle stall.
    rand_ready = 1;
    for (int f = 0; f < 6; f++) begin
      if (f == 2) low_left = 5;
      nx = $urandom_range(0, 700);
      ny = $urandom_range(0, 520);
      applyStimulus(0, 0, 1'b1);
      for (int b = 0; b < 24; b++) begin
        if (b == 5) setMouse(nx, ny);
        xs = clampi(nx, H_RES - 1) - 2 + $urandom_range(0, 11);
        ys = clampi(ny, V_RES - 1) - 2 + $urandom_range(0, 11);
        xs = (xs < 0) ? 0 : clampi(xs, H_RES - 1);
        ys = (ys < 0) ? 0 : clampi(ys, V_RES - 1);
        applyStimulus(xs, ys, 1'b0);
      end
    end
    rand_ready = 0;
    m_ready = 1'b1;
    idle(4);

    // Reset with beats in flight must discard them and home the cursor.
    m_ready = 1'b0;
    applyStimulus(5, 5, 1'b1);
    applyStimulus(6, 6, 1'b0);
    s_valid = 1'b1;
    reset_n = 1'b0;
    repeat (3) cycle();
    s_valid = 1'b0;
    reset_n = 1'b1;
    m_ready = 1'b1;
    idle(2);
    checkOutput("rst_cursor_x", 32'(cursor_x), 32'd0);
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    applyStimulus(2, 2, 1'b0);
    checkOutput("rst_lat_stage1", 32'(m_valid), 32'd0);
    cycle();
    checkOutput("rst_lat_out", 32'(m_valid), 32'd1);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
    checkOutput("drain_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mouse_cursor_overlay.md
# mouse_cursor_overlay

Consumes the packed 19-bit cursor position driven by the HPS-writable mouse PIO and overlays a solid square cursor onto the grayscale pixel stream heading to the video output. Position updates are clamped to the visible area and committed only at start-of-frame, so a cursor never tears mid-frame. The pixel path is a 2-stage valid/ready pipeline with full backpressure support.

## Interface
- H_RES, 640: visible width in pixels
- V_RES, 480: visible height in lines
- CUR_SIZE, 8: cursor edge length in pixels
- PIX_W, 8: pixel width
- CUR_COLOR, 8'hFF: cursor pixel value (PIX_W bits)
- BLINK_FRAMES, 30: frames per blink half-period (used only with CURSOR_BLINK_EN)

- clk  in  1  system clock; the only clock
- reset_n  in  1  reset, synchronous, active-low
- mouse_pos  in  19  PIO word: [9:0] x, [18:10] y
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_x  in  10  pixel column
- s_y  in  9  pixel line
- s_sof  in  1  first pixel of frame
- s_pixel  in  PIX_W  pixel value
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream ready
- m_sof  out  1  s_sof, delayed
- m_pixel  out  PIX_W  pixel value after overlay
- cursor_x  out  10  committed cursor column
- cursor_y  out  9  committed cursor line

## Operation
- mouse_pos is registered into pos_q every cycle (1-cycle sample lag).
- Clamp: x > H_RES-1 → H_RES-1; y > V_RES-1 → V_RES-1. Clamp is applied to pos_q.
- pending set whenever clamped pos_q ≠ {cursor_y, cursor_x}; cleared on commit.
- Commit: on an accepted beat with s_sof=1 and pending=1, cursor_x/cursor_y ← clamped pos_q. The sof beat itself and all later beats of that frame use the new position.
- Hit: cursor_x ≤ s_x < cursor_x+CUR_SIZE and cursor_y ≤ s_y < cursor_y+CUR_SIZE. Sums computed 1 bit wider (11/10 bits); no wrap. Cursor clips at right/bottom edges naturally.
- Stage 1 registers pixel, sof, hit; stage 2 registers m_pixel = (hit & visible) ? CUR_COLOR : pixel.
- visible is constant 1 unless CURSOR_BLINK_EN is defined.
- Pipeline: each stage advances when empty or the next stage advances; s_ready = stage-1 advance condition. No beat dropped, duplicated or reordered.

## Timing
- Reset (reset_n=0 at a clk edge): m_valid=0, m_sof=0, m_pixel=0, cursor_x=0, cursor_y=0, pos_q=0, pending=0, both stages empty; s_ready=1 from the first cycle after reset. Reset mid-frame discards in-flight beats.
- Latency: accepted beat appears on m_valid 2 cycles later with m_ready=1; throughput 1 beat/cycle.
- m_ready=0: outputs hold stable; up to 2 beats buffered, then s_ready=0 in the same cycle stage 1 cannot advance.
- mouse_pos change in the same cycle as an accepted sof beat: not visible in pos_q yet; commits at the next sof.
- Multiple mouse_pos changes within a frame: only the value present in pos_q at sof commits.
- s_sof is otherwise passthrough; the block never checks s_x/s_y ordering.

## Configuration
- CURSOR_BLINK_EN defined: frame counter (width clog2(BLINK_FRAMES)) increments on each accepted sof beat. At BLINK_FRAMES-1 it wraps to 0 and toggles visible. Reset: counter 0, visible 1. Hidden frames pass pixels unchanged; commit still occurs.
- Not defined: no counter; visible tied 1; cursor drawn every frame.

## Test plan
- Reset mid-stream: reset_n=0 for 3 cycles while streaming → m_valid=0, cursor_x=cursor_y=0, no stale beat after release; first accepted beat exits 2 cycles later.
- Commit at sof: mouse_pos x=100,y=50 mid-frame → current frame unchanged at (100,50). Next frame: (100..107, 50..57) output 8'hFF; (108,50) and (100,58) pass input.
- Clamp: x=1000,y=500 → cursor_x=639, cursor_y=479 after next sof; only pixel (639,479) overwritten.
- Backpressure: continuous s_valid with random m_ready (incl. 5-cycle low) → output sequence equals input sequence with overlay applied; s_ready low only while both stages full.
- Same-cycle race: mouse_pos changes to (200,100) on the sof cycle → frame N keeps old cursor; frame N+1 draws at (200,100).
- CURSOR_BLINK_EN, BLINK_FRAMES=2: cursor drawn in frames 0-1, hidden 2-3, drawn 4-5; cursor_x/cursor_y still update during hidden frames.
